dac_arbiter: RTL and testbench

Shares one DAC SPI master between up to N requesters, e.g. the control loop and a CPU-side direct-access or waveform port. A requester holds the bus for as long as it keeps its `ss` asserted, so a multi-transfer sequence such as a register-read command followed by a readback word completes without interleaving. The block sits between the requesters' `to_dac`/`from_dac`/`dac_ss`/`dac_arm`/`dac_finished` signals and the single SPI master instance.

---
 rtl/dac_arbiter_pkg.sv | 25 ++
 rtl/dac_arbiter_rr_pick.sv | 35 +++
 rtl/dac_arbiter.sv | 127 ++++++++++++
 tb/tb_dac_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_arbiter_pkg.sv
// Shared definitions for the DAC bus arbiter: DAC word layout, register codes
// and the arbiter state encoding.
package dac_arbiter_pkg;

    localparam int DAC_CODE_WID = 4;
    localparam int DAC_DATA_WID = 20;
    localparam int DAC_WORD_WID = DAC_CODE_WID + DAC_DATA_WID;

    localparam logic [DAC_CODE_WID-1:0] DAC_CODE_WRITE = 4'b0001;
    localparam logic [DAC_CODE_WID-1:0] DAC_CODE_READ  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_GUARD = 2'd2
    } arb_state_t;

    function automatic logic [DAC_WORD_WID-1:0] dac_word(
        input logic [DAC_CODE_WID-1:0] code,
        input logic [DAC_DATA_WID-1:0] data
    );
        return {code, data};
    endfunction

endpackage

// File: rtl/dac_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo N. An out-of-range pointer is treated as zero.
module rr_pick #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] idx_o,
    output logic             valid_o
);

    always_comb begin
        int base;
        int j;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        base    = (int'(ptr_i) < N) ? int'(ptr_i) : 0;
        j       = 0;
        for (int off = 0; off < N; off++) begin
            j = base + off;
            if (j >= N) begin
                j = j - N;
            end
            if (!valid_o && req_i[j]) begin
                valid_o    = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = PTR_W'(j);
            end
        end
    end

endmodule

// File: rtl/dac_arbiter.sv
// Shares one DAC SPI master between N requesters. An owner keeps the bus while
// its ss is high; after release the master ss is held low for a guard time.
module dac_arbiter
    import dac_arbiter_pkg::*;
#(
    parameter int N         = 2,
    parameter int DAC_WID   = DAC_WORD_WID,
    parameter int GUARD_CYC = 2,
    parameter int GUARD_WID = 4
) (
    input  logic                 clk,
    input  logic                 rst_L,
    input  logic [N-1:0]         req_ss,
    input  logic [N-1:0]         req_arm,
    input  logic [N*DAC_WID-1:0] req_to_dac,
    output logic [N-1:0]         req_finished,
    output logic [N-1:0]         grant,
    output logic [DAC_WID-1:0]   from_dac,
    output logic                 mst_ss,
    output logic                 mst_arm,
    output logic [DAC_WID-1:0]   mst_to_dac,
    input  logic [DAC_WID-1:0]   mst_from_dac,
    input  logic                 mst_finished,
    output arb_state_t           dbg_state
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(N - 1);

    arb_state_t             state_q;
    logic [GUARD_WID-1:0]   guard_q;
    logic [PTR_W-1:0]       rr_ptr_q;
    logic [PTR_W-1:0]       rr_ptr_d;
    logic [N-1:0]           grant_q;
    logic                   mst_ss_q;
    logic                   mst_arm_q;
    logic [DAC_WID-1:0]     mst_to_dac_q;

    logic [N-1:0]           pick_onehot;
    logic [PTR_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic                   owner_ss;
    logic                   owner_arm;
    logic [DAC_WID-1:0]     owner_word;

    rr_pick #(
        .N     (N),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req_i   (req_ss),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_onehot),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // The one-hot grant doubles as the owner select mask.
    assign owner_ss  = |(grant_q & req_ss);
    assign owner_arm = |(grant_q & req_arm);
    assign rr_ptr_d  = (pick_idx == LAST_IDX) ? '0 : pick_idx + PTR_W'(1);

    always_comb begin
        owner_word = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q[i]) begin
                owner_word = owner_word | req_to_dac[i*DAC_WID +: DAC_WID];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q      <= ST_IDLE;
            guard_q      <= '0;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            mst_ss_q     <= 1'b0;
            mst_arm_q    <= 1'b0;
            mst_to_dac_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant_q  <= pick_onehot;
                        mst_ss_q <= 1'b1;
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= ST_OWNED;
                    end
                end
                ST_OWNED: begin
                    if (owner_ss) begin
                        mst_arm_q    <= owner_arm;
                        mst_to_dac_q <= owner_word;
                    end else begin
                        // Releasing aborts any in-flight transfer; the master
                        // ends it on ss low, so mst_finished is not awaited.
                        grant_q      <= '0;
                        mst_ss_q     <= 1'b0;
                        mst_arm_q    <= 1'b0;
                        mst_to_dac_q <= '0;
                        guard_q      <= GUARD_WID'(GUARD_CYC - 1);
                        state_q      <= ST_GUARD;
                    end
                end
                ST_GUARD: begin
                    if (guard_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        guard_q <= guard_q - GUARD_WID'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant        = grant_q;
    assign mst_ss       = mst_ss_q;
    assign mst_arm      = mst_arm_q;
    assign mst_to_dac   = mst_to_dac_q;
    assign req_finished = grant_q & {N{mst_finished}};
    assign from_dac     = mst_from_dac;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_dac_arbiter.sv
// Bench for dac_arbiter: vector table, hand-written abort/reset sequences and a
// randomized run against a rule-level model of ownership and guard time.
module tb_dac_arbiter;
    import dac_arbiter_pkg::*;

    localparam int N  = 2;
    localparam int DW = 24;
    localparam int GC = 2;
    localparam int GW = 4;

    logic            clk;
    logic            rst_L;
    logic [N-1:0]    req_ss;
    logic [N-1:0]    req_arm;
    logic [N*DW-1:0] req_to_dac;
    logic [N-1:0]    req_finished;
    logic [N-1:0]    grant;
    logic [DW-1:0]   from_dac;
    logic            mst_ss;
    logic            mst_arm;
    logic [DW-1:0]   mst_to_dac;
    logic [DW-1:0]   mst_from_dac;
    logic            mst_finished;
    arb_state_t      dbg_state;

    dac_arbiter #(
        .N         (N),
        .DAC_WID   (DW),
        .GUARD_CYC (GC),
        .GUARD_WID (GW)
    ) dut (
        .clk          (clk),
        .rst_L        (rst_L),
        .req_ss       (req_ss),
        .req_arm      (req_arm),
        .req_to_dac   (req_to_dac),
        .req_finished (req_finished),
        .grant        (grant),
        .from_dac     (from_dac),
        .mst_ss       (mst_ss),
        .mst_arm      (mst_arm),
        .mst_to_dac   (mst_to_dac),
        .mst_from_dac (mst_from_dac),
        .mst_finished (mst_finished),
        .dbg_state    (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] ss, input logic [1:0] arm,
                         input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                         input logic fin, input logic [DW-1:0] from_w);
        req_ss       = ss;
        req_arm      = arm;
        req_to_dac   = {w1, w0};
        mst_finished = fin;
        mst_from_dac = from_w;
    endtask

    task automatic check_outs(input string tag, input logic [1:0] e_grant, input logic e_ss,
                              input logic e_arm, input logic [DW-1:0] e_dac, input logic [1:0] e_fin);
        check({tag, ".grant"},    32'(grant),        32'(e_grant));
        check({tag, ".mst_ss"},   32'(mst_ss),       32'(e_ss));
        check({tag, ".mst_arm"},  32'(mst_arm),      32'(e_arm));
        check({tag, ".mst_dac"},  32'(mst_to_dac),   32'(e_dac));
        check({tag, ".req_fin"},  32'(req_finished), 32'(e_fin));
    endtask

    typedef struct {
        logic [1:0]    ss;
        logic [1:0]    arm;
        logic [DW-1:0] w0;
        logic [DW-1:0] w1;
        logic          fin;
        logic [DW-1:0] from_w;
        logic [1:0]    e_grant;
        logic          e_ss;
        logic          e_arm;
        logic [DW-1:0] e_dac;
        logic [1:0]    e_fin;
    } vec_t;

    vec_t tbl[18];

    // reference model state
    int            m_owner;
    int            m_ptr;
    int            m_edge;
    int            m_earliest;
    logic          m_arm;
    logic [DW-1:0] m_dac;

    initial begin
        logic [1:0]    s_ss;
        logic [1:0]    s_arm;
        logic [DW-1:0] s_w[N];
        logic          s_fin;
        logic [1:0]    e_grant;
        logic [1:0]    e_fin;

        //               ss     arm    w0         w1         fin   from       grant  ss    arm   dac        fin
        tbl[0]  = '{2'b01, 2'b00, 24'h000000, 24'h000000, 1'b0, 24'h000000, 2'b01, 1'b1, 1'b0, 24'h000000, 2'b00};
        tbl[1]  = '{2'b01, 2'b01, 24'h1ABCDE, 24'h000000, 1'b0, 24'h000000, 2'b01, 1'b1, 1'b1, 24'h1ABCDE, 2'b00};
        tbl[2]  = '{2'b01, 2'b00, 24'h1ABCDE, 24'h000000, 1'b1, 24'h000000, 2'b01, 1'b1, 1'b0, 24'h1ABCDE, 2'b01};
        tbl[3]  = '{2'b01, 2'b01, 24'h900000, 24'h000000, 1'b0, 24'h000000, 2'b01, 1'b1, 1'b1, 24'h900000, 2'b00};
        tbl[4]  = '{2'b01, 2'b00, 24'h900000, 24'h000000, 1'b1, 24'h000000, 2'b01, 1'b1, 1'b0, 24'h900000, 2'b01};
        tbl[5]  = '{2'b01, 2'b01, 24'h000000, 24'h000000, 1'b0, 24'h000000, 2'b01, 1'b1, 1'b1, 24'h000000, 2'b00};
        tbl[6]  = '{2'b01, 2'b00, 24'h000000, 24'h000000, 1'b1, 24'h012345, 2'b01, 1'b1, 1'b0, 24'h000000, 2'b01};
        tbl[7]  = '{2'b11, 2'b10, 24'h000000, 24'h0AAAAA, 1'b0, 24'h000000, 2'b01, 1'b1, 1'b0, 24'h000000, 2'b00};
        tbl[8]  = '{2'b10, 2'b00, 24'h000000, 24'h000000, 1'b0, 24'h000000, 2'b00, 1'b0, 1'b0, 24'h000000, 2'b00};
        tbl[9]  = '{2'b11, 2'b00, 24'h000000, 24'h000000, 1'b0, 24'h000000, 2'b00, 1'b0, 1'b0, 24'h000000, 2'b00};
        tbl[10] = '{2'b11, 2'b00, 24'h000000, 24'h000000, 1'b0, 24'h000000, 2'b00, 1'b0, 1'b0, 24'h000000, 2'b00};
        tbl[11] = '{2'b11, 2'b00, 24'h000000, 24'h1555AA, 1'b0, 24'h000000, 2'b10, 1'b1, 1'b0, 24'h000000, 2'b00};
        tbl[12] = '{2'b11, 2'b11, 24'h1F0F0F, 24'h1555AA, 1'b0, 24'h000000, 2'b10, 1'b1, 1'b1, 24'h1555AA, 2'b00};
        tbl[13] = '{2'b11, 2'b00, 24'h1F0F0F, 24'h1555AA, 1'b1, 24'h000000, 2'b10, 1'b1, 1'b0, 24'h1555AA, 2'b10};
        tbl[14] = '{2'b01, 2'b00, 24'h000000, 24'h000000, 1'b0, 24'h000000, 2'b00, 1'b0, 1'b0, 24'h000000, 2'b00};
        tbl[15] = '{2'b01, 2'b00, 24'h000000, 24'h000000, 1'b0, 24'h000000, 2'b00, 1'b0, 1'b0, 24'h000000, 2'b00};
        tbl[16] = '{2'b01, 2'b00, 24'h000000, 24'h000000, 1'b0, 24'h000000, 2'b00, 1'b0, 1'b0, 24'h000000, 2'b00};
        tbl[17] = '{2'b01, 2'b00, 24'h000000, 24'h000000, 1'b0, 24'h000000, 2'b01, 1'b1, 1'b0, 24'h000000, 2'b00};

        // reset state
        rst_L = 1'b0;
        drive(2'b00, 2'b00, '0, '0, 1'b0, 24'h0);
        #12;
        check_outs("reset", 2'b00, 1'b0, 1'b0, 24'h0, 2'b00);
        check("reset.state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        rst_L = 1'b1;

        // table: single requester, read sequence, contention
        for (int r = 0; r < 18; r++) begin
            drive(tbl[r].ss, tbl[r].arm, tbl[r].w0, tbl[r].w1, tbl[r].fin, tbl[r].from_w);
            step();
            check_outs($sformatf("row%0d", r), tbl[r].e_grant, tbl[r].e_ss, tbl[r].e_arm,
                       tbl[r].e_dac, tbl[r].e_fin);
            check($sformatf("row%0d.from_dac", r), 32'(from_dac), 32'(tbl[r].from_w));
        end

        // abort: owner 0 drops ss mid-transfer, late finished goes nowhere
        drive(2'b01, 2'b01, 24'h1FFFFF, 24'h0, 1'b0, 24'h0);
        step();
        check_outs("abort.arm", 2'b01, 1'b1, 1'b1, 24'h1FFFFF, 2'b00);
        drive(2'b00, 2'b00, 24'h0, 24'h0, 1'b0, 24'h0);
        step();
        check_outs("abort.drop", 2'b00, 1'b0, 1'b0, 24'h0, 2'b00);
        mst_finished = 1'b1;
        #1;
        check("abort.late_fin", 32'(req_finished), 32'(2'b00));
        mst_finished = 1'b0;
        step();
        step();
        step();

        // async reset mid-transfer, then requester 1 alone after release
        drive(2'b10, 2'b00, 24'h0, 24'h0ABCDE, 1'b0, 24'h0);
        step();
        check("arst.pre_grant", 32'(grant), 32'(2'b10));
        req_arm = 2'b10;
        step();
        check("arst.pre_arm", 32'(mst_arm), 32'(1'b1));
        #3;
        rst_L = 1'b0;
        #1;
        check_outs("arst.async", 2'b00, 1'b0, 1'b0, 24'h0, 2'b00);
        check("arst.state", 32'(dbg_state), 32'(ST_IDLE));
        req_arm = 2'b00;
        @(posedge clk);
        @(negedge clk);
        rst_L = 1'b1;
        step();
        check_outs("arst.regrant", 2'b10, 1'b1, 1'b0, 24'h0, 2'b00);

        // randomized run against the rule-level model
        rst_L = 1'b0;
        drive(2'b00, 2'b00, '0, '0, 1'b0, 24'h0);
        #7;
        @(negedge clk);
        rst_L = 1'b1;
        m_owner    = -1;
        m_ptr      = 0;
        m_edge     = 0;
        m_earliest = 0;
        m_arm      = 1'b0;
        m_dac      = '0;
        s_ss       = 2'b00;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 7) == 0) s_ss[b] = ~s_ss[b];
            end
            s_arm = 2'($urandom_range(0, 3));
            for (int b = 0; b < N; b++) s_w[b] = 24'($urandom);
            s_fin = 1'($urandom_range(0, 1));
            drive(s_ss, s_arm, s_w[0], s_w[1], s_fin, 24'($urandom));
            step();
            m_edge++;
            if (m_owner < 0) begin
                if (m_edge >= m_earliest) begin
                    for (int off = 0; off < N; off++) begin
                        int c;
                        c = (m_ptr + off) % N;
                        if (m_owner < 0 && s_ss[c]) begin
                            m_owner = c;
                        end
                    end
                    if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
                end
            end else if (s_ss[m_owner]) begin
                m_arm = s_arm[m_owner];
                m_dac = s_w[m_owner];
            end else begin
                m_owner    = -1;
                m_arm      = 1'b0;
                m_dac      = '0;
                m_earliest = m_edge + GC + 1;
            end
            e_grant = (m_owner >= 0) ? 2'(1 << m_owner) : 2'b00;
            e_fin   = s_fin ? e_grant : 2'b00;
            check_outs($sformatf("rand%0d", cyc), e_grant, (m_owner >= 0), m_arm, m_dac, e_fin);
            check($sformatf("rand%0d.from_dac", cyc), 32'(from_dac), 32'(mst_from_dac));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
